// File: rtl/axi4_slave_mem.sv
// AXI4 memory responder: word-addressed register array behind independent
// write (AW/W/B) and read (AR/R) state machines, one transaction in flight per path.
module axi4_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);
  localparam int unsigned IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] r_mem [MEM_DEPTH];

  function automatic logic f_illegal(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size != 3'b010) || (burst == 2'b11) ||
           ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] addr,
                                                   input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] v_wrap, v_lower, v_inc;
    v_wrap  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << 2;
    v_lower = addr & ~(v_wrap - ADDR_WIDTH'(1));
    v_inc   = addr + ADDR_WIDTH'(4);
    case (burst)
      2'b01:   f_next = v_inc;
      2'b10:   f_next = (v_inc == (v_lower + v_wrap)) ? v_lower : v_inc;
      default: f_next = addr;
    endcase
  endfunction

  // ---------------- write path ----------------
  w_state_t              r_wstate, w_wstate_nxt;
  logic [ADDR_WIDTH-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]            r_wlen, w_wlen_nxt, r_wcnt, w_wcnt_nxt;
  logic [1:0]            r_wburst, w_wburst_nxt, r_bresp, w_bresp_nxt;
  logic                  r_wbad, w_wbad_nxt, r_wlerr, w_wlerr_nxt;
  logic                  r_awready, w_awready_nxt, r_wready, w_wready_nxt, r_bvalid, w_bvalid_nxt;
  logic                  w_mem_we, w_wfinal;
  logic [IDX_W-1:0]      w_widx;

  assign w_widx   = r_waddr[IDX_W+1:2];
  assign w_wfinal = (r_wcnt == r_wlen);

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_waddr_nxt   = r_waddr;
    w_wlen_nxt    = r_wlen;
    w_wcnt_nxt    = r_wcnt;
    w_wburst_nxt  = r_wburst;
    w_wbad_nxt    = r_wbad;
    w_wlerr_nxt   = r_wlerr;
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_mem_we      = 1'b0;
    case (r_wstate)
      W_IDLE: if (awvalid && r_awready) begin
        w_waddr_nxt   = awaddr;
        w_wlen_nxt    = awlen;
        w_wburst_nxt  = awburst;
        w_wbad_nxt    = f_illegal(awlen, awsize, awburst);
        w_wcnt_nxt    = 8'd0;
        w_wlerr_nxt   = 1'b0;
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b1;
        w_wstate_nxt  = W_DATA;
      end
      W_DATA: if (wvalid && r_wready) begin
        w_mem_we    = !r_wbad;
        w_waddr_nxt = f_next(r_waddr, r_wlen, r_wburst);
        w_wcnt_nxt  = r_wcnt + 8'd1;
        if (wlast != w_wfinal) w_wlerr_nxt = 1'b1;
        // beat count, not wlast, decides the end of the burst
        if (w_wfinal) begin
          w_wready_nxt = 1'b0;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = (r_wbad || r_wlerr || !wlast) ? RESP_SLVERR : RESP_OKAY;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: if (bready && r_bvalid) begin
        w_bvalid_nxt  = 1'b0;
        w_bresp_nxt   = RESP_OKAY;
        w_awready_nxt = 1'b1;
        w_wstate_nxt  = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wstate  <= W_IDLE;
      r_waddr   <= '0;
      r_wlen    <= 8'd0;
      r_wcnt    <= 8'd0;
      r_wburst  <= 2'b00;
      r_wbad    <= 1'b0;
      r_wlerr   <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wlen    <= w_wlen_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_wburst  <= w_wburst_nxt;
      r_wbad    <= w_wbad_nxt;
      r_wlerr   <= w_wlerr_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Storage is not reset; byte lanes follow wstrb.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_nxt, w_raddr_adv;
  logic [7:0]            r_rlen, w_rlen_nxt, r_rcnt, w_rcnt_nxt;
  logic [1:0]            r_rburst, w_rburst_nxt, r_rresp, w_rresp_nxt;
  logic                  r_rbad, w_rbad_nxt, w_ar_bad;
  logic                  r_arready, w_arready_nxt, r_rvalid, w_rvalid_nxt, r_rlast, w_rlast_nxt;
  logic [31:0]           r_rdata, w_rdata_nxt;
  logic [IDX_W-1:0]      w_aridx, w_rnidx;

  assign w_raddr_adv = f_next(r_raddr, r_rlen, r_rburst);
  assign w_aridx     = araddr[IDX_W+1:2];
  assign w_rnidx     = w_raddr_adv[IDX_W+1:2];
  assign w_ar_bad    = f_illegal(arlen, arsize, arburst);

  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_raddr_nxt   = r_raddr;
    w_rlen_nxt    = r_rlen;
    w_rcnt_nxt    = r_rcnt;
    w_rburst_nxt  = r_rburst;
    w_rbad_nxt    = r_rbad;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rlast_nxt   = r_rlast;
    w_rresp_nxt   = r_rresp;
    w_rdata_nxt   = r_rdata;
    case (r_rstate)
      R_IDLE: if (arvalid && r_arready) begin
        w_raddr_nxt   = araddr;
        w_rlen_nxt    = arlen;
        w_rburst_nxt  = arburst;
        w_rbad_nxt    = w_ar_bad;
        w_rcnt_nxt    = 8'd0;
        w_rdata_nxt   = w_ar_bad ? 32'd0 : r_mem[w_aridx];
        w_rresp_nxt   = w_ar_bad ? RESP_SLVERR : RESP_OKAY;
        w_rlast_nxt   = (arlen == 8'd0);
        w_rvalid_nxt  = 1'b1;
        w_arready_nxt = 1'b0;
        w_rstate_nxt  = R_DATA;
      end
      R_DATA: if (rready && r_rvalid) begin
        if (r_rlast) begin
          w_rvalid_nxt  = 1'b0;
          w_rlast_nxt   = 1'b0;
          w_arready_nxt = 1'b1;
          w_rstate_nxt  = R_IDLE;
        end else begin
          // prefetch the next beat on the accepting edge for back-to-back beats
          w_raddr_nxt = w_raddr_adv;
          w_rdata_nxt = r_rbad ? 32'd0 : r_mem[w_rnidx];
          w_rcnt_nxt  = r_rcnt + 8'd1;
          w_rlast_nxt = ((r_rcnt + 8'd1) == r_rlen);
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstate  <= R_IDLE;
      r_raddr   <= '0;
      r_rlen    <= 8'd0;
      r_rcnt    <= 8'd0;
      r_rburst  <= 2'b00;
      r_rbad    <= 1'b0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= 32'd0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_raddr   <= w_raddr_nxt;
      r_rlen    <= w_rlen_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_rburst  <= w_rburst_nxt;
      r_rbad    <= w_rbad_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rresp   <= w_rresp_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomized bench for axi4_slave_mem against a beat-level memory model with
// queued expected R/B responses checked every cycle.
module tb_axi4_slave_mem;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = 8'd0, arlen = 8'd0;
  logic [2:0]    awsize = 3'd2, arsize = 3'd2;
  logic [1:0]    awburst = 2'd1, arburst = 2'd1;
  logic          awvalid = 1'b0, arvalid = 1'b0;
  logic          awready, arready, wready, bvalid, rvalid, rlast;
  logic [31:0]   wdata = 32'd0, rdata;
  logic [3:0]    wstrb = 4'h0;
  logic          wlast = 1'b0, wvalid = 1'b0;
  logic          bready = 1'b1, rready = 1'b1;
  logic [1:0]    bresp, rresp;

  axi4_slave_mem #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
  } rbeat_t;

  rbeat_t      exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] m_mem [DEPTH];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          r_popped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // A request is legal only for 4-byte beats, a defined burst, and WRAP of 2/4/8/16 beats.
  function automatic bit m_illegal(input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    int n;
    n = int'(len) + 1;
    return (sz != 3'd2) || (bu == 2'd3) || ((bu == 2'd2) && !(n == 2 || n == 4 || n == 8 || n == 16));
  endfunction

  function automatic logic [31:0] m_beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] bu, input int i);
    logic [31:0] wb, lower;
    case (bu)
      2'd1: return a + 32'(4 * i);
      2'd2: begin
        wb    = 32'((int'(len) + 1) * 4);
        lower = a & ~(wb - 32'd1);
        return lower + ((a - lower + 32'(4 * i)) % wb);
      end
      default: return a;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Single compare process: reset values, R beats and B responses against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_ctrl", 32'({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp}), 32'h300);
      chk("reset_rdata", rdata, 32'd0);
    end else begin
      if (rvalid) begin
        if (exp_r.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
        else begin
          chk("rdata", rdata, exp_r[0].data);
          chk("rlast", 32'(rlast), 32'(exp_r[0].last));
          chk("rresp", 32'(rresp), 32'(exp_r[0].resp));
          if (rready) begin
            void'(exp_r.pop_front());
            r_popped++;
          end
        end
      end
      if (bvalid) begin
        if (exp_b.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
        else begin
          chk("bresp", 32'(bresp), 32'(exp_b[0]));
          if (bready) void'(exp_b.pop_front());
        end
      end
    end
  end

  // strb==0 selects a random strobe per beat; lerr_beat flips wlast on that beat.
  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu, input logic [31:0] d0, input logic [3:0] strb,
                          input int lerr_beat, input int bdelay, input int gap_pct);
    logic [31:0] dv [256];
    logic [3:0]  sv [256];
    logic        lv [256];
    bit          bad;
    int          guard, idx;
    bad = m_illegal(len, sz, bu);
    for (int i = 0; i <= int'(len); i++) begin
      dv[i] = d0 + 32'(i);
      sv[i] = (strb == 4'h0) ? 4'($urandom_range(0, 15)) : strb;
      lv[i] = (i == int'(len)) ^ (i == lerr_beat);
      if (!bad) begin
        idx = m_idx(m_beat_addr(a, len, bu, i));
        for (int b = 0; b < 4; b++) if (sv[i][b]) m_mem[idx][8*b +: 8] = dv[i][8*b +: 8];
      end
    end
    exp_b.push_back((bad || (lerr_beat >= 0 && lerr_beat <= int'(len))) ? 2'b10 : 2'b00);
    bready  = (bdelay == 0);
    awaddr  = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!awready && guard < 50) begin @(negedge clk); guard++; end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk) chk("aw_busy", 32'({awready, wready}), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i <= int'(len); i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        wvalid = 1'b0; @(posedge clk); #1;
      end
      wdata = dv[i]; wstrb = sv[i]; wlast = lv[i]; wvalid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!wready && guard < 50) begin @(negedge clk); guard++; end
      if (!wready) chk("w_timeout", 32'(wready), 32'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("b_valid_rise", 32'(bvalid), 32'd1);
    chk("w_closed", 32'(wready), 32'd0);
    for (int k = 0; k < bdelay; k++) begin
      @(posedge clk); #1;
      @(negedge clk) chk("b_hold", 32'(bvalid), 32'd1);
    end
    @(posedge clk); #1 bready = 1'b1;
    guard = 0;
    while (exp_b.size() > 0 && guard < 50) begin @(posedge clk); #1; guard++; end
    if (exp_b.size() > 0) begin
      chk("b_timeout", 32'(exp_b.size()), 32'd0);
      exp_b.delete();
    end
  endtask

  // hold_at: drop rready for 3 cycles when that beat is on the bus.
  // rst_at: assert reset while that beat is on the bus.
  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input int stall_pct, input int hold_at, input int rst_at);
    bit   bad, held;
    int   guard, start;
    bad  = m_illegal(len, sz, bu);
    held = 1'b0;
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{data: bad ? 32'd0 : m_mem[m_idx(m_beat_addr(a, len, bu, i))],
                        last: (i == int'(len)), resp: bad ? 2'b10 : 2'b00});
    start  = r_popped;
    rready = 1'b1;
    araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!arready && guard < 50) begin @(negedge clk); guard++; end
    if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk) chk("r_first", 32'({rvalid, arready}), 32'd2);
    guard = 0;
    while (exp_r.size() > 0 && guard < 3000) begin
      @(posedge clk); #1; guard++;
      if (rst_at >= 0 && (r_popped - start) == rst_at) begin
        reset = 1'b0;
        #1 chk("rst_rvalid_async", 32'(rvalid), 32'd0);
        exp_r.delete();
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        break;
      end
      if (hold_at >= 0 && (r_popped - start) == hold_at && !held) begin
        held   = 1'b1;
        rready = 1'b0;
        repeat (3) begin
          @(negedge clk) chk("r_hold_valid", 32'(rvalid), 32'd1);
          @(posedge clk); #1;
        end
        rready = 1'b1;
      end else if (stall_pct > 0) begin
        rready = ($urandom_range(0, 99) >= stall_pct);
      end
    end
    if (exp_r.size() > 0) begin
      chk("r_timeout", 32'(exp_r.size()), 32'd0);
      exp_r.delete();
    end
    rready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  len;
    logic [1:0]  bu;
    logic [2:0]  sz;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // preload every word so the model knows the whole array
    do_write(32'h0, 8'd255, 3'd2, 2'd1, $urandom, 4'hF, -1, 0, 0);

    do_write(32'h1, 8'd1, 3'd2, 2'd0, 32'h100, 4'hF, -1, 0, 0);
    chk("pin_fixed", m_mem[0], 32'h101);
    do_read(32'h1, 8'd1, 3'd2, 2'd0, 0, -1, -1);

    do_write(32'h8, 8'd5, 3'd2, 2'd1, 32'h200, 4'hF, -1, 0, 0);
    chk("pin_incr_lo", m_mem[2], 32'h200);
    chk("pin_incr_hi", m_mem[7], 32'h205);
    do_read(32'h8, 8'd5, 3'd2, 2'd1, 0, -1, -1);

    do_write(32'h30, 8'd7, 3'd2, 2'd2, 32'h300, 4'hF, -1, 0, 0);
    chk("pin_wrap_addr4", m_beat_addr(32'h30, 8'd7, 2'd2, 4), 32'h20);
    chk("pin_wrap_w12", m_mem[12], 32'h300);
    chk("pin_wrap_w8", m_mem[8], 32'h304);
    chk("pin_wrap_w11", m_mem[11], 32'h307);
    do_read(32'h30, 8'd7, 3'd2, 2'd2, 0, -1, -1);

    do_read(32'h8, 8'd5, 3'd2, 2'd1, 0, 2, -1);
    do_write(32'h80, 8'd2, 3'd2, 2'd1, 32'h400, 4'hF, -1, 4, 0);

    do_write(32'h40, 8'd0, 3'd2, 2'd3, 32'hDEAD, 4'hF, -1, 0, 0);
    do_read(32'h40, 8'd0, 3'd2, 2'd1, 0, -1, -1);
    do_read(32'h30, 8'd2, 3'd2, 2'd2, 0, -1, -1);
    do_write(32'h50, 8'd1, 3'd2, 2'd1, 32'h500, 4'hF, 0, 0, 0);
    do_read(32'h50, 8'd1, 3'd2, 2'd1, 0, -1, -1);

    do_read(32'h8, 8'd5, 3'd2, 2'd1, 0, -1, 2);
    @(negedge clk) chk("rst_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    do_read(32'h30, 8'd7, 3'd2, 2'd2, 0, -1, -1);

    fork
      do_write(32'h190, 8'd3, 3'd2, 2'd1, 32'h600, 4'hF, -1, 1, 0);
      do_read(32'h50, 8'd3, 3'd2, 2'd1, 0, -1, -1);
    join

    for (int t = 0; t < 60; t++) begin
      a   = $urandom;
      bu  = 2'($urandom_range(0, 3));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      len = 8'($urandom_range(0, 15));
      if (bu == 2'd2 && $urandom_range(0, 3) != 0) len = 8'((2 << $urandom_range(0, 3)) - 1);
      if (bu == 2'd2) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1)
        do_write(a, len, sz, bu, $urandom, ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1,
                 int'($urandom_range(0, 3)), 20);
      else
        do_read(a, len, sz, bu, 30, -1, -1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_slave_mem.md
Name: axi4_slave_mem

Overview:
- AXI4 memory-mapped responder; the slave end of the AXI4 interface that the axi4_top user-side master drives.
- Accepts write and read bursts of type FIXED, INCR and WRAP, and stores data in an internal word-addressed register array.
- The write path (AW/W/B) and the read path (AR/R) run as independent state machines. Each path allows one outstanding transaction.
- Used as the memory model behind the master in axi4_top and as a standalone responder for master-side benches.

Parameters:
- ADDR_WIDTH, 32, width of awaddr/araddr.
- MEM_DEPTH, 256, number of 32-bit words; must be a power of 2. IDX_W = log2(MEM_DEPTH).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- awaddr  in  ADDR_WIDTH  write start address.
- awlen  in  8  beats minus 1.
- awsize  in  3  bytes per beat (log2).
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- awvalid  in  1 / awready  out  1  AW handshake.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  final write beat.
- wvalid  in  1 / wready  out  1  W handshake.
- bresp  out  2  00 OKAY, 10 SLVERR.
- bvalid  out  1 / bready  in  1  B handshake.
- araddr, arlen, arsize, arburst  in  ADDR_WIDTH/8/3/2  read request, same encodings as AW.
- arvalid  in  1 / arready  out  1  AR handshake.
- rdata  out  32  read data.
- rresp  out  2  read response, same encoding as bresp.
- rlast  out  1  final read beat.
- rvalid  out  1 / rready  in  1  R handshake.

Behaviour:
- **Reset values:** awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bresp, rresp=00; rdata=0. The memory array is not reset.
- **Reset mid-burst:** both FSMs return to IDLE asynchronously and all valids drop immediately. No response is issued for the aborted transaction. Beats already written stay written.
- **Handshake rule:** a transfer occurs on a clk edge where valid and ready are both 1. A valid output, once high, holds its payload stable until the transfer.
- **Address mapping:** word index = addr[IDX_W+1:2]. addr[1:0] is ignored, so unaligned starts map to the containing word. Higher address bits alias.
- **Legality:** a request is SLVERR if any of these holds:
  - size != 010
  - burst == 11
  - WRAP with len not in {1,3,7,15}

  An illegal write accepts all beats but writes nothing. An illegal read returns len+1 beats with rdata=0.
- **Next-address rule, per beat:**
  - FIXED: address unchanged.
  - INCR: addr + 4.
  - WRAP: wrap_bytes=(len+1)*4 and lower=addr & ~(wrap_bytes-1); next = addr+4, or lower if addr+4 == lower+wrap_bytes.
  - Arithmetic is ADDR_WIDTH bits; INCR overflow wraps silently.
- **Write FSM:**
  - W_IDLE: awready=1. On AW transfer, latch request, set beat count=0 → W_DATA with awready=0, wready=1.
  - W_DATA: on each W transfer, write bytes where wstrb=1, advance the address, increment the count. The beat with count == len is final: wready=0, → W_RESP.
  - wlast mismatch (wlast=1 before the final beat, or 0 on it) sets bresp=SLVERR. Beat counting still follows awlen.
  - W_RESP: bvalid=1 until B transfer → W_IDLE, awready=1.
- **Read FSM:**
  - R_IDLE: arready=1. On AR transfer, rdata is registered from mem[start index] → R_DATA. rvalid=1 on the next cycle (1-cycle latency), arready=0.
  - R_DATA: on each R transfer that is not last, load the next beat's word the same edge. rvalid stays 1, giving back-to-back beats at full throughput. rlast=1 when beat == len.
  - On the last transfer: rvalid=0, rlast=0 → R_IDLE.
- **Simultaneous events:** a write and a read to the same word on the same edge return the old data. AW and AR may be accepted on the same cycle.

Test Plan:
- **FIXED write:** addr 0x1, len 1, data 0x100 then 0x101, wstrb=F → bresp=00. FIXED read of addr 0x1, len 1 → rdata 0x101, 0x101; rlast on the 2nd beat.
- **INCR:** write addr 0x8, len 5, data 0x200..0x205 → words 2..7. INCR read of the same request → 0x200..0x205 back-to-back, first rvalid 1 cycle after AR.
- **WRAP:** write addr 48 (0x30), len 7, data 0x300..0x307 → beat addresses 0x30,0x34,0x38,0x3C,0x20,0x24,0x28,0x2C. WRAP read of the same request returns 0x300..0x307 in order.
- **Read backpressure:** hold rready=0 for 3 cycles mid-burst → rdata/rlast held stable and no beat lost. Then toggle bready late → bvalid held until accepted.
- **Error cases:**
  - awburst=11, len 0, data 0xDEAD → bresp=10 and the target word unchanged.
  - WRAP with len 2 → rresp=10 on all 3 beats.
  - wlast early on beat 0 of len 1 → bresp=10.
- **Reset mid-burst:** assert reset during beat 2 of a len-5 INCR read → rvalid=0 immediately. After release, arready=1 and a new read succeeds.
